// File: rtl/posit_quire_mac_scheduler_pkg.sv
// PositPkg: posit field-width helpers and unpacked/product operand types
package PositPkg;
  function automatic int frac_bits(int w, int es);
    return w - es - 3;
  endfunction
  function automatic int bias(int w, int es);
    return (w - 2) << es;
  endfunction
  function automatic int exp_bits(int w, int es);
    return $clog2(2 * bias(w, es) + 1);
  endfunction
  function automatic int unpackedBits(int w, int es);
    return 3 + exp_bits(w, es) + frac_bits(w, es);
  endfunction
  function automatic int getExpProductBits(int w, int es);
    return exp_bits(w, es) + 1;
  endfunction
  function automatic int getFracProductBits(int w, int es);
    return 2 * (frac_bits(w, es) + 1);
  endfunction
  localparam int DEF_W = 8;
  localparam int DEF_ES = 1;
  typedef struct packed {
    logic sign;
    logic isInf;
    logic isZero;
    logic [exp_bits(DEF_W, DEF_ES)-1:0] exp;
    logic [frac_bits(DEF_W, DEF_ES)-1:0] frac;
  } upos_t;
  typedef struct packed {
    logic sign;
    logic isInf;
    logic isZero;
    logic [getExpProductBits(DEF_W, DEF_ES)-1:0] exp;
    logic [getFracProductBits(DEF_W, DEF_ES)-1:0] frac;
  } prod_t;
endpackage

// File: rtl/posit_quire_mac_scheduler_if.sv
// posit_quire_mac_scheduler_if: requester operand streams in, tagged product stream out
interface posit_quire_mac_scheduler_if
  import PositPkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  parameter int NUM_REQ = 4,
  parameter int COUNT_BITS = 16
);
  localparam int UB = unpackedBits(WIDTH, ES);
  logic [NUM_REQ-1:0] inValid, inReady, inLast;
  logic [NUM_REQ-1:0][UB-1:0] inA, inB;
  logic outValid, outReady, outFirst, outLast, outIsInf, outIsZero, outSign;
  logic [$clog2(NUM_REQ)-1:0] outTag;
  logic [COUNT_BITS-1:0] outIdx;
  logic [getExpProductBits(WIDTH, ES)-1:0] outExp;
  logic [getFracProductBits(WIDTH, ES)-1:0] outFrac;
  modport master(
    output inValid, inLast, inA, inB, outReady,
    input inReady, outValid, outTag, outFirst, outLast, outIdx, outIsInf, outIsZero, outSign, outExp, outFrac
  );
  modport slave(
    input inValid, inLast, inA, inB, outReady,
    output inReady, outValid, outTag, outFirst, outLast, outIdx, outIsInf, outIsZero, outSign, outExp, outFrac
  );
endinterface

// File: rtl/posit_quire_mac_scheduler_arbiter.sv
// posit_rr_arbiter: round-robin grant starting after ptr, or pinned to owner while locked
module posit_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               lock,
  input  logic [IW-1:0]      owner,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] c;
  always_comb begin
    c = '0;
    idx = owner;
    any = lock & req[owner];
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % NUM_REQ);
      if (!lock && req[c]) begin
        idx = c;
        any = 1'b1;
      end
    end
    gnt = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/posit_quire_mac_scheduler.sv
// posit_quire_mac_scheduler: round-robin shared posit multiplier feeding per-requester quires
// POSIT_QUIRE_SCHED_LOCK_EN: hold the grant on one requester until its last pair is accepted
module posit_quire_mac_scheduler
  import PositPkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  parameter int NUM_REQ = 4,
  parameter int COUNT_BITS = 16
) (
  input logic clock,
  input logic reset,
  posit_quire_mac_scheduler_if.slave bus
);
  localparam int EB = exp_bits(WIDTH, ES);
  localparam int FB = frac_bits(WIDTH, ES);
  localparam int PE = getExpProductBits(WIDTH, ES);
  localparam int PF = getFracProductBits(WIDTH, ES);
  localparam int IW = $clog2(NUM_REQ);
  typedef struct packed {
    logic sign;
    logic isInf;
    logic isZero;
    logic [EB-1:0] exp;
    logic [FB-1:0] frac;
  } pos_t;
  typedef struct packed {
    logic sign;
    logic isInf;
    logic isZero;
    logic [PE-1:0] exp;
    logic [PF-1:0] frac;
  } prd_t;
  typedef struct packed {
    logic [IW-1:0] tag;
    logic first;
    logic last;
    logic [COUNT_BITS-1:0] idx;
  } meta_t;
  logic [IW-1:0] ptr, gidx;
  logic [NUM_REQ-1:0] gnt, busy;
  logic [NUM_REQ-1:0][COUNT_BITS-1:0] cnt;
  logic any, lock, acc, s1_v, s2_v, s1_ld, s2_ld, inf, zero;
  pos_t s1_a, s1_b;
  meta_t m, s1_m, s2_m;
  prd_t p, s2_p;
`ifdef POSIT_QUIRE_SCHED_LOCK_EN
  // ptr is the last granted requester, so it doubles as the lock owner
  always_ff @(posedge clock) lock <= reset ? 1'b0 : acc ? !bus.inLast[gidx] : lock;
`else
  assign lock = 1'b0;
`endif
  posit_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.inValid), .ptr(ptr), .lock(lock), .owner(ptr), .gnt(gnt), .idx(gidx), .any(any)
  );
  assign s2_ld = !s2_v | bus.outReady;
  assign s1_ld = !s1_v | s2_ld;
  assign acc = any & s1_ld & !reset;
  assign bus.inReady = gnt & {NUM_REQ{s1_ld & !reset}};
  assign m = '{tag: gidx, first: !busy[gidx], last: bus.inLast[gidx], idx: busy[gidx] ? cnt[gidx] : '0};
  assign inf = s1_a.isInf | s1_b.isInf;
  assign zero = !inf & (s1_a.isZero | s1_b.isZero);
  assign p = '{sign: s1_a.sign ^ s1_b.sign, isInf: inf, isZero: zero,
               exp: (inf | zero) ? '0 : PE'(s1_a.exp) + PE'(s1_b.exp),
               frac: (inf | zero) ? '0 : PF'({1'b1, s1_a.frac}) * PF'({1'b1, s1_b.frac})};
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= IW'(NUM_REQ - 1);
      busy <= '0;
      cnt <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_m <= '0;
      s2_m <= '0;
      s2_p <= '0;
    end else begin
      if (s1_ld) s1_v <= acc;
      if (acc) begin
        ptr <= gidx;
        s1_a <= pos_t'(bus.inA[gidx]);
        s1_b <= pos_t'(bus.inB[gidx]);
        s1_m <= m;
        busy[gidx] <= !m.last;
        cnt[gidx] <= m.last ? '0 : (&m.idx ? m.idx : m.idx + 1'b1);
      end
      if (s2_ld) begin
        s2_v <= s1_v;
        s2_m <= s1_m;
        s2_p <= p;
      end
    end
  end
  assign bus.outValid = s2_v;
  assign bus.outTag = s2_m.tag;
  assign bus.outFirst = s2_m.first;
  assign bus.outLast = s2_m.last;
  assign bus.outIdx = s2_m.idx;
  assign bus.outSign = s2_p.sign;
  assign bus.outIsInf = s2_p.isInf;
  assign bus.outIsZero = s2_p.isZero;
  assign bus.outExp = s2_p.exp;
  assign bus.outFrac = s2_p.frac;
endmodule

// File: tb/tb_posit_quire_mac_scheduler.sv
// tb_posit_quire_mac_scheduler: product vector table, directed corner sequences, randomized scoreboard
`timescale 1ns/1ps
module tb_posit_quire_mac_scheduler;
  import PositPkg::*;
  localparam int N = 4;
  localparam int CB = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  posit_quire_mac_scheduler_if #(.WIDTH(8), .ES(1), .NUM_REQ(N), .COUNT_BITS(CB)) bus ();
  posit_quire_mac_scheduler #(.WIDTH(8), .ES(1), .NUM_REQ(N), .COUNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  typedef struct {
    upos_t a;
    upos_t b;
    prod_t p;
  } vec_t;
  typedef struct {
    int tag;
    bit first;
    bit last;
    int idx;
    prod_t p;
  } exp_t;
  int checks = 0;
  int failures = 0;
  vec_t vt[7];
  exp_t q[$];
  exp_t e;
  upos_t one;
  prod_t p_one;
  int r, k, cyc, nidx, nacc, mptr, mown, n, g;
  int acnt[N];
  int ocnt[N];
  int pos[N];
  bit mlock, rdy, stalled;
  logic [N-1:0] v, lst, er;
  logic [63:0] held;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic upos_t mk(bit s, bit inf, bit z, int ex, int f);
    return '{sign: s, isInf: inf, isZero: z, exp: 5'(ex), frac: 4'(f)};
  endfunction

  function automatic prod_t mkp(bit s, bit inf, bit z, int ex, int f);
    return '{sign: s, isInf: inf, isZero: z, exp: 6'(ex), frac: 10'(f)};
  endfunction

  // value-level reference: scales add, significands (with hidden one) multiply
  function automatic prod_t model(upos_t a, upos_t b);
    prod_t rp = '0;
    rp.sign = a.sign ^ b.sign;
    rp.isInf = a.isInf | b.isInf;
    rp.isZero = !rp.isInf && (a.isZero || b.isZero);
    if (!rp.isInf && !rp.isZero) begin
      rp.exp = 6'(int'(a.exp) + int'(b.exp));
      rp.frac = 10'((16 + int'(a.frac)) * (16 + int'(b.frac)));
    end
    return rp;
  endfunction

  function automatic upos_t rnd_pos();
    int s = $urandom_range(0, 9);
    return mk(1'($urandom), s == 0, s == 1, $urandom_range(0, 24), $urandom_range(0, 15));
  endfunction

  function automatic logic [63:0] snap();
    return 64'({bus.outTag, bus.outFirst, bus.outLast, bus.outIdx, bus.outSign, bus.outIsInf,
                bus.outIsZero, bus.outExp, bus.outFrac});
  endfunction

  function automatic int exp_grant(logic [N-1:0] req);
    if (mlock) return req[mown] ? mown : -1;
    for (int i = 1; i <= N; i++) if (req[(mptr + i) % N]) return (mptr + i) % N;
    return -1;
  endfunction

  task automatic idle();
    bus.inValid = '0;
    bus.inLast = '0;
    bus.inA = '0;
    bus.inB = '0;
    bus.outReady = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_out(string nm, int tag, bit first, bit last, int idx, prod_t ep);
    chk({nm, ".valid"}, bus.outValid, 1);
    chk({nm, ".tag"}, bus.outTag, tag);
    chk({nm, ".first"}, bus.outFirst, first);
    chk({nm, ".last"}, bus.outLast, last);
    chk({nm, ".idx"}, bus.outIdx, idx);
    chk({nm, ".prod"}, {bus.outSign, bus.outIsInf, bus.outIsZero, bus.outExp, bus.outFrac}, ep);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    one = mk(0, 0, 0, 12, 0);
    p_one = mkp(0, 0, 0, 24, 256);
    vt[0] = '{one, one, p_one};
    vt[1] = '{mk(0, 1, 0, 0, 0), mk(1, 0, 1, 0, 0), mkp(1, 1, 0, 0, 0)};
    vt[2] = '{mk(0, 0, 1, 0, 0), mk(0, 0, 0, 13, 5), mkp(0, 0, 1, 0, 0)};
    vt[3] = '{mk(1, 0, 0, 12, 8), mk(0, 0, 0, 13, 0), mkp(1, 0, 0, 25, 384)};
    vt[4] = '{mk(0, 0, 0, 24, 15), mk(1, 0, 0, 24, 15), mkp(1, 0, 0, 48, 961)};
    vt[5] = '{mk(1, 0, 0, 3, 7), mk(1, 1, 0, 9, 2), mkp(0, 1, 0, 0, 0)};
    vt[6] = '{mk(0, 0, 0, 0, 1), mk(0, 0, 0, 0, 1), mkp(0, 0, 0, 0, 289)};
    idle();
    repeat (2) @(negedge clock);
    bus.inValid = '1;
    #1;
    chk("rst.inReady", bus.inReady, 0);
    chk("rst.outValid", bus.outValid, 0);
    chk("rst.fields", snap(), 0);
    reset = 1'b0;
    #1;
    chk("rst.first_grant", bus.inReady, 4'b0001);
    bus.inValid = '0;
    // product table, one single-element dot product per vector
    for (int i = 0; i < 7; i++) begin
      r = i % N;
      @(negedge clock);
      idle();
      bus.inValid[r] = 1'b1;
      bus.inLast[r] = 1'b1;
      bus.inA[r] = vt[i].a;
      bus.inB[r] = vt[i].b;
      #1;
      chk("vec.inReady", bus.inReady, 4'b0001 << r);
      @(negedge clock);
      idle();
      #1;
      chk("vec.latency", bus.outValid, 0);
      @(negedge clock);
      #1;
      chk_out("vec", r, 1, 1, 0, vt[i].p);
    end
    // three 1.0 x 1.0 pairs on requester 0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      idle();
      if (c < 3) begin
        bus.inValid[0] = 1'b1;
        bus.inA[0] = one;
        bus.inB[0] = one;
        bus.inLast[0] = c == 2;
      end
      #1;
      if (c < 3) chk("seq1.inReady", bus.inReady[0], 1);
      chk("seq1.outValid", bus.outValid, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) chk_out("seq1", 0, c == 2, c == 4, c - 2, p_one);
    end
    // all four requesters streaming 4-element dot products
    do_reset();
    k = 0;
    cyc = 0;
    for (int i = 0; i < N; i++) begin acnt[i] = 0; ocnt[i] = 0; end
    while (k < 16 && cyc < 100) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        bus.inValid[i] = acnt[i] < 4;
        bus.inLast[i] = acnt[i] == 3;
        bus.inA[i] = one;
        bus.inB[i] = one;
      end
      #1;
      for (int i = 0; i < N; i++) if (bus.inReady[i] && bus.inValid[i]) acnt[i]++;
      if (bus.outValid) begin
`ifdef POSIT_QUIRE_SCHED_LOCK_EN
        g = (k / 4) % N;
`else
        g = k % N;
`endif
        chk_out("stream", g, ocnt[g] == 0, ocnt[g] == 3, ocnt[g], p_one);
        ocnt[g]++;
        k++;
      end
      cyc++;
    end
    chk("stream.count", k, 16);
    // backpressure: downstream stalls for 5 cycles
    do_reset();
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      bus.inValid[1] = 1'b1;
      bus.inA[1] = one;
      bus.inB[1] = one;
      bus.outReady = 1'b0;
      #1;
      chk("bp.inReady", bus.inReady[1], c < 2);
      if (bus.inReady[1]) nacc++;
      if (c >= 2) chk_out("bp.hold", 1, 1, 0, 0, p_one);
    end
    nidx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      bus.outReady = 1'b1;
      bus.inValid[1] = c < 8;
      bus.inLast[1] = c == 7;
      #1;
      if (c == 0) chk("bp.release_ready", bus.inReady[1], 1);
      if (bus.inReady[1] && bus.inValid[1]) nacc++;
      if (bus.outValid) begin
        chk("bp.idx", bus.outIdx, nidx);
        nidx++;
      end
    end
    chk("bp.count", nidx, 10);
    chk("bp.accepts", nacc, 10);
    // reset after 2 of 5 elements of requester 2
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      bus.inValid[2] = 1'b1;
      bus.inA[2] = one;
      bus.inB[2] = one;
      #1;
      chk("mid.inReady", bus.inReady[2], 1);
    end
    @(negedge clock);
    reset = 1'b1;
    idle();
    #1;
    chk("mid.ready_in_reset", bus.inReady, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.inValid = '1;
    bus.inLast = '1;
    bus.inA[0] = one;
    bus.inB[0] = one;
    #1;
    chk("mid.outValid", bus.outValid, 0);
    chk("mid.grant0", bus.inReady, 4'b0001);
    @(negedge clock);
    idle();
    bus.inValid[2] = 1'b1;
    bus.inLast[2] = 1'b1;
    bus.inA[2] = mk(0, 0, 0, 10, 3);
    bus.inB[2] = one;
    #1;
    chk("mid.req2_ready", bus.inReady[2], 1);
    @(negedge clock);
    idle();
    #1;
    chk_out("mid.req0", 0, 1, 1, 0, p_one);
    @(negedge clock);
    #1;
    chk_out("mid.req2", 2, 1, 1, 0, mkp(0, 0, 0, 22, 19 * 16));
    // randomized traffic against the scoreboard
    do_reset();
    mptr = N - 1;
    mown = 0;
    mlock = 0;
    n = 0;
    stalled = 0;
    held = '0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clock);
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        lst[i] = $urandom_range(0, 3) == 0;
        bus.inA[i] = rnd_pos();
        bus.inB[i] = rnd_pos();
      end
      bus.inValid = v;
      bus.inLast = lst;
      bus.outReady = $urandom_range(0, 3) != 0;
      #1;
      if (stalled) begin
        chk("rnd.hold_valid", bus.outValid, 1);
        chk("rnd.hold_fields", snap(), held);
      end
      g = exp_grant(v);
      rdy = g >= 0 && (n < 2 || bus.outReady);
      er = rdy ? N'(1) << g : '0;
      chk("rnd.inReady", bus.inReady, er);
      if (bus.outValid && bus.outReady) begin
        chk("rnd.expected_any", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_out("rnd", e.tag, e.first, e.last, e.idx, e.p);
          n--;
        end
      end
      if (rdy) begin
        q.push_back('{g, pos[g] == 0, lst[g], pos[g], model(upos_t'(bus.inA[g]), upos_t'(bus.inB[g]))});
        pos[g] = lst[g] ? 0 : pos[g] + 1;
        mptr = g;
        mown = g;
`ifdef POSIT_QUIRE_SCHED_LOCK_EN
        mlock = !lst[g];
`endif
        n++;
      end
      stalled = bus.outValid && !bus.outReady;
      held = snap();
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      idle();
      #1;
      if (bus.outValid) begin
        chk("drain.expected_any", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_out("drain", e.tag, e.first, e.last, e.idx, e.p);
        end
      end
    end
    chk("drain.empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_quire_mac_scheduler.md
# posit_quire_mac_scheduler

Shares one posit multiply-for-quire datapath among `NUM_REQ` requesters, each streaming (a, b) operand pairs of its own dot product. Arbitrates round-robin, registers the operands, forms the product, and emits a tagged product stream with first/last markers. A downstream quire bank uses this stream to clear and accumulate the per-requester quire.

## Interface
- `WIDTH`, 8: posit width
- `ES`, 1: posit exponent bits
- `NUM_REQ`, 4: requester count, 2..16
- `COUNT_BITS`, 16: element-index counter width
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `inValid`  in  NUM_REQ  per-requester operand valid
- `inReady`  out  NUM_REQ  per-requester accept
- `inA`, `inB`  in  NUM_REQ×`PositPkg::unpackedBits(WIDTH,ES)`  unpacked posits (sign, isInf, isZero, exponent, fraction)
- `inLast`  in  NUM_REQ  final pair of that requester's dot product
- `outValid`  out  1  product valid
- `outReady`  in  1  downstream accept
- `outTag`  out  clog2(NUM_REQ)  owning requester
- `outFirst`, `outLast`  out  1  first/last product of the dot product
- `outIdx`  out  COUNT_BITS  element index within the dot product, starting at 0
- `outIsInf`, `outIsZero`, `outSign`  out  1  product flags
- `outExp`  out  `getExpProductBits(WIDTH,ES)`  biased product exponent
- `outFrac`  out  `getFracProductBits(WIDTH,ES)`  product fraction, hidden bits included

## Operation
- Arbiter: `ptr` holds the last granted requester. The grant goes to the first `inValid` requester scanning `ptr+1 … ptr+NUM_REQ` modulo `NUM_REQ`.
- `inReady[i]` = grant==i AND S1 can accept. It is combinational from `inValid` and pipeline state; at most one bit is high.
- `ptr` updates only on an accepted handshake.
- S1 register: holds a, b, tag, first, last, idx.
- S2 register: holds the product fields.
- Product rules:
  - isInf = aInf|bInf.
  - isZero = !isInf & (aZero|bZero).
  - sign = aSign^bSign.
  - exp = aExp+bExp, but 0 when inf or zero.
  - frac = {1,aFrac}×{1,bFrac}, but 0 when inf or zero.
- Per-requester state: `busy[i]` and `cnt[i]` (COUNT_BITS).
- On accept from requester i:
  - first = !busy[i]; idx = busy ? cnt[i] : 0.
  - Then busy[i] = !inLast, and cnt[i] = inLast ? 0 : idx+1.
- `cnt` saturates at all-ones. Once saturated, idx keeps reporting all-ones for the remaining elements.
- A single-element dot product has first=last=1.
- Arbitration never reorders elements of one requester. Products appear in acceptance order.

## Timing
- Latency: accept at cycle N, product on `outValid` at N+2 when there is no backpressure.
- S2 loads when S2 is empty or `outReady`. S1 loads when S1 is empty or S1 moves into S2.
- Throughput is 1 product/cycle under continuous `outReady`.
- Full backpressure: both stages hold, and `inReady` stays 0 until S2 drains.
- Output fields hold stable while `outValid & !outReady`.
- Simultaneous accept and drain in one cycle is legal; there is no bubble.
- Reset values:
  - `outValid`=0, all S1/S2 valids=0, `inReady`=0 during reset.
  - `busy`=0, `cnt`=0.
  - `ptr`=NUM_REQ-1, so requester 0 wins first.
  - All output data fields are 0.
- Reset mid-operation discards in-flight products and partial dot products. The next element from any requester is marked first.

## Configuration
- `POSIT_QUIRE_SCHED_LOCK_EN` defined: an accept with `inLast`=0 locks the grant to that requester. Others see `inReady`=0 until its `inLast` pair is accepted, then round-robin resumes from that requester. Products of one dot product are then contiguous. The lock clears on reset.
- Macro undefined: the grant re-arbitrates every element, so dot products interleave at element granularity.

## Structure
- `PositPkg`:
  - `unpackedBits`, `getExpProductBits`, `getFracProductBits`.
  - The unpacked posit packed struct typedef.
  - A product struct typedef (sign, isInf, isZero, exp, frac).
- Sub-module `posit_rr_arbiter` (NUM_REQ). It takes request vector, pointer and an optional lock/owner, and returns a one-hot grant and encoded index.
- The product logic is instantiated inline, not as a sub-module.

## Test plan
- Single requester 0, WIDTH=8 ES=1, pairs (1.0,1.0) ×3 with last on the 3rd:
  - Products at cycles 2, 3, 4 after the first accept.
  - idx 0, 1, 2; first on idx 0, last on idx 2; exp = 2×bias; frac = 1<<(2×fracBits).
- All 4 requesters continuously valid, lock undefined:
  - Grant order is 0,1,2,3,0,….
  - Each tag's idx increments by 1 per product; no requester starves.
- Same stimulus with `POSIT_QUIRE_SCHED_LOCK_EN` and 4-element dot products:
  - Output tags are 0,0,0,0,1,1,1,1,…, each block framed first…last.
- `outReady` held low for 5 cycles mid-stream:
  - `inReady` drops after 2 accepts; output fields stay stable.
  - On release, no product is lost or duplicated; the idx sequence is continuous.
- Operands inf×zero and zero×normal:
  - inf×zero gives isInf=1, isZero=0, exp=0, frac=0.
  - zero×normal gives isZero=1, exp=0, frac=0.
- `reset` asserted after requester 2 has 2 of 5 elements accepted:
  - `outValid`=0 next cycle.
  - Requester 2's next accepted element has first=1, idx=0.
  - Requester 0 wins first if all requesters are valid.
